keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Scans a 4x4 active-low matrix keypad by driving one column low at a time and sampling the rows. Each key press is debounced and encoded as a 4-bit code. The code is held in a one-entry valid/ack buffer for the consumer logic, which can forward it to the display/decoder path. This is the input-side counterpart of the multiplexed LED-matrix and 7-segment drivers: those drive a matrix outward, this reads a matrix inward.

Parameters:
SCAN_DIV, 50000, clock cycles each column stays driven (one scan slot); must be >= 4.
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a press or a release; must be >= 1.

Ports:
clock  input  1  system clock; the only clock in the block.
reset  input  1  synchronous, active-high reset.
row_in  input  4  keypad rows, active-low, asynchronous to clock.
col_out  output  4  keypad column drive, active-low, exactly one bit low at any time.
key_code  output  4  accepted key code = column_index*4 + row_index.
key_valid  output  1  key_code holds an unconsumed key.
key_ack  input  1  consumer accepts key_code; effective only while key_valid=1.
key_held  output  1  an accepted key is still pressed (FSM in HELD).
key_overrun  output  1  sticky: a key was dropped because the buffer was full.

Behaviour:
- Clock/reset: single clock `clock`; reset is synchronous and active-high, port `reset`.
- Reset values: col_out=4'b1110, slot counter=0, column index=0, state=SCAN, key_code=0, key_valid=0, key_held=0, key_overrun=0, synchronizer flops=4'b1111, debounce counters=0.
- Synchronizer: row_in passes through a 2-flop synchronizer before use.
- Column timing:
  - Column index c advances 0,1,2,3,0... every SCAN_DIV cycles; col_out = ~(1<<c).
  - Rows are sampled on the last cycle of each slot.
  - One full scan = 4*SCAN_DIV cycles and ends at the column-3 sample.
- Scan result, evaluated at the end of each scan:
  - NONE: no low row in any column.
  - SINGLE(code): exactly one low row bit across all four samples.
  - MULTI: more than one low bit in total (ghosting/chord).
- FSM, transitions evaluated only at scan end:
  - SCAN: SINGLE(k) -> DEBOUNCE, cand=k, cnt=1. If DEBOUNCE_SCANS=1, go straight to accept. Otherwise stay in SCAN.
  - DEBOUNCE: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go to HELD. Any other result (NONE, MULTI, different code) -> SCAN, cnt=0.
  - HELD: NONE -> rel+1; when rel reaches DEBOUNCE_SCANS -> SCAN, rel=0. Any non-NONE result -> rel=0, stay in HELD. No new key is accepted while in HELD.
- Accept, occurring the cycle after the final scan sample:
  - If key_valid=0: load key_code=cand, key_valid=1.
  - If key_valid=1 and key_ack=1 in the same cycle: load the new code, key_valid stays 1, no overrun.
  - If key_valid=1 and no ack: drop the new code, keep the old one, set key_overrun=1.
- Handshake:
  - key_ack=1 while key_valid=1 clears key_valid on the next edge.
  - key_ack while key_valid=0 is ignored.
  - key_code holds its value after ack until the next accept.
- key_overrun clears only on reset.
- Latency: a press stable from before a scan start is reported DEBOUNCE_SCANS*4*SCAN_DIV (+2 sync) cycles later.
- Reset mid-scan or mid-debounce aborts all state. A held key must then be re-debounced from SCAN.
- key_held = (state==HELD).

Decomposition:
- Shared package keypad_pkg:
  - state encoding SCAN/DEBOUNCE/HELD (2 bits);
  - scan-result encoding NONE/SINGLE/MULTI;
  - constant KP_COLS=4, KP_ROWS=4, KP_CODE_W=4.
- Sub-module keypad_col_timer:
  - slot counter plus column index;
  - drives col_out;
  - emits a sample_strobe pulse and a scan_end pulse.
- FSM, result accumulation and output buffer stay in keypad_scanner.

Test Plan:
All tests use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-cycle scan.
1. Reset -> col_out=4'b1110, key_valid=0, key_overrun=0. After 4 cycles col_out=4'b1101; after 16 cycles it is back to 4'b1110.
2. Hold row 2 low only while column 1 is driven, for 5 scans -> key_valid=1 with key_code=6 after 3 scans; key_held=1. Release for 3 scans -> key_held=0.
3. Bounce: press code 6 for 2 scans, release 1 scan, press 2 scans -> no key_valid. A third consecutive scan then yields key_code=6.
4. Rows 0 and 1 low in column 0 (codes 0 and 1 together) for 6 scans -> no key_valid; FSM remains in SCAN.
5. Accept code 5, no ack, release, accept code 9 -> key_code stays 5 and key_overrun=1. Ack -> key_valid=0 next cycle.
6. Code 3 pending; key_ack asserted in the same cycle as acceptance of code 12 -> key_code=12, key_valid=1, key_overrun=0. Also: assert reset during DEBOUNCE -> all outputs return to reset values.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned KP_COLS   = 4;
  localparam int unsigned KP_ROWS   = 4;
  localparam int unsigned KP_CODE_W = 4;
  localparam int unsigned KP_COL_W  = 2;
  localparam int unsigned KP_ROW_W  = 2;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kp_state_e;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } kp_result_e;

  // Key code is column-major: column*4 + row.
  function automatic logic [KP_CODE_W-1:0] kp_encode(input logic [KP_COL_W-1:0] col,
                                                      input logic [KP_ROW_W-1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/keypad_col_timer.sv
// Column scan timing: slot counter, active-low column drive and sample/scan-end strobes.
module keypad_col_timer
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic [KP_COLS-1:0]  col_out_o,
  output logic [KP_COL_W-1:0] col_idx_o,
  output logic                sample_strobe_o,
  output logic                scan_end_o
);

  localparam int unsigned      CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [KP_COL_W-1:0] COL_LAST = KP_COL_W'(KP_COLS - 1);

  logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [KP_COL_W-1:0] col_idx_q, col_idx_d;
  logic [KP_COLS-1:0]  col_out_q;
  logic                sample_strobe_q, scan_end_q;
  logic                slot_last_d;

  always_comb begin
    slot_cnt_d = slot_cnt_q + CNT_W'(1);
    col_idx_d  = col_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      col_idx_d  = col_idx_q + KP_COL_W'(1);
    end
    slot_last_d = (slot_cnt_d == SLOT_LAST);
  end

  // Strobes are registered one cycle ahead so they line up with the slot's last cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_cnt_q      <= '0;
      col_idx_q       <= '0;
      col_out_q       <= 4'b1110;
      sample_strobe_q <= 1'b0;
      scan_end_q      <= 1'b0;
    end else begin
      slot_cnt_q      <= slot_cnt_d;
      col_idx_q       <= col_idx_d;
      col_out_q       <= ~(KP_COLS'(1) << col_idx_d);
      sample_strobe_q <= slot_last_d;
      scan_end_q      <= slot_last_d && (col_idx_d == COL_LAST);
    end
  end

  assign col_out_o       = col_out_q;
  assign col_idx_o       = col_idx_q;
  assign sample_strobe_o = sample_strobe_q;
  assign scan_end_o      = scan_end_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: synchronise rows, classify each full scan,
// debounce press/release and hold accepted codes in a one-entry valid/ack buffer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KP_ROWS-1:0]   row_in,
  output logic [KP_COLS-1:0]   col_out,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 key_valid,
  input  logic                 key_ack,
  output logic                 key_held,
  output logic                 key_overrun
);

  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_SCANS - 1);

  logic [KP_COL_W-1:0]  col_idx;
  logic                 sample_strobe;
  logic                 scan_end;

  logic [KP_ROWS-1:0]   row_s1_q, row_s2_q;
  logic [1:0]           acc_cnt_q, acc_cnt_d;
  logic [KP_CODE_W-1:0] acc_code_q;

  logic [KP_ROWS-1:0]   lows;
  logic [2:0]           pop;
  logic [2:0]           sum;
  logic [KP_ROW_W-1:0]  row_idx;
  logic [KP_CODE_W-1:0] sample_code;
  logic [KP_CODE_W-1:0] res_code;
  kp_result_e           res;
  logic                 accept_c;

  kp_state_e            state_q;
  logic [KP_CODE_W-1:0] cand_q;
  logic [DB_W-1:0]      db_cnt_q;
  logic [DB_W-1:0]      rel_cnt_q;
  logic                 held_q;

  logic [KP_CODE_W-1:0] key_code_q;
  logic                 key_valid_q;
  logic                 key_overrun_q;

  keypad_col_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_timer (
    .clk_i           (clock),
    .rst_i           (reset),
    .col_out_o       (col_out),
    .col_idx_o       (col_idx),
    .sample_strobe_o (sample_strobe),
    .scan_end_o      (scan_end)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
    end
  end

  // Classify the current sample merged with what earlier columns of this scan saw.
  always_comb begin
    lows    = ~row_s2_q;
    pop     = '0;
    row_idx = '0;
    for (int r = 0; r < int'(KP_ROWS); r++) begin
      if (lows[r]) begin
        pop     = pop + 3'd1;
        row_idx = KP_ROW_W'(r);
      end
    end
    sample_code = kp_encode(col_idx, row_idx);
    sum         = 3'(acc_cnt_q) + pop;
    acc_cnt_d   = (sum > 3'd2) ? 2'd2 : sum[1:0];
    res_code    = (pop == 3'd1) ? sample_code : acc_code_q;
    if (sum == 3'd0) begin
      res = RES_NONE;
    end else if (sum == 3'd1) begin
      res = RES_SINGLE;
    end else begin
      res = RES_MULTI;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (sample_strobe) begin
      if (scan_end) begin
        acc_cnt_q  <= '0;
        acc_code_q <= '0;
      end else begin
        acc_cnt_q <= acc_cnt_d;
        if (pop == 3'd1) begin
          acc_code_q <= sample_code;
        end
      end
    end
  end

  always_comb begin
    accept_c = 1'b0;
    if (scan_end && (res == RES_SINGLE)) begin
      if ((state_q == ST_SCAN) && (DEBOUNCE_SCANS == 1)) begin
        accept_c = 1'b1;
      end else if ((state_q == ST_DEBOUNCE) && (res_code == cand_q) && (db_cnt_q == DB_LAST)) begin
        accept_c = 1'b1;
      end
    end
  end

  // Press/release debounce; every transition happens on a scan boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      cand_q    <= '0;
      db_cnt_q  <= '0;
      rel_cnt_q <= '0;
      held_q    <= 1'b0;
    end else if (scan_end) begin
      case (state_q)
        ST_SCAN: begin
          if (res == RES_SINGLE) begin
            cand_q <= res_code;
            if (accept_c) begin
              state_q  <= ST_HELD;
              held_q   <= 1'b1;
              db_cnt_q <= '0;
            end else begin
              state_q  <= ST_DEBOUNCE;
              db_cnt_q <= DB_W'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if ((res == RES_SINGLE) && (res_code == cand_q)) begin
            if (accept_c) begin
              state_q  <= ST_HELD;
              held_q   <= 1'b1;
              db_cnt_q <= '0;
            end else begin
              db_cnt_q <= db_cnt_q + DB_W'(1);
            end
          end else begin
            state_q  <= ST_SCAN;
            db_cnt_q <= '0;
          end
        end
        ST_HELD: begin
          if (res == RES_NONE) begin
            if (rel_cnt_q == DB_LAST) begin
              state_q   <= ST_SCAN;
              held_q    <= 1'b0;
              rel_cnt_q <= '0;
            end else begin
              rel_cnt_q <= rel_cnt_q + DB_W'(1);
            end
          end else begin
            rel_cnt_q <= '0;
          end
        end
        default: begin
          state_q   <= ST_SCAN;
          held_q    <= 1'b0;
          db_cnt_q  <= '0;
          rel_cnt_q <= '0;
        end
      endcase
    end
  end

  // One-entry output buffer; an ack in the accept cycle frees room for the new code.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_overrun_q <= 1'b0;
    end else if (accept_c) begin
      if (!key_valid_q || key_ack) begin
        key_code_q  <= res_code;
        key_valid_q <= 1'b1;
      end else begin
        key_overrun_q <= 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_q <= 1'b0;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = held_q;
  assign key_overrun = key_overrun_q;

endmodule
